// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage of the monocycle processor.
//
// Holds the program counter. Fetches one word per instruction from
// instruction memory over a ready handshake. Presents the latched
// instruction and its opcode to control for one EXEC cycle. Computes the
// next PC from the jump/branch decision. Stops on the halt opcode or on a
// misaligned jump-register target.
//
// Optional feature: define FETCH_PERF_EN to build the saturating
// instr_count / stall_count performance counters. When it is undefined,
// both outputs are tied to zero and no counter registers exist.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr  fetch request and byte address (= pc)
//   imem_rdata/ready    instruction word and its valid strobe (FETCH only)
//   instr, opcode       latched instruction and instr[31:26]
//   instr_valid         high for exactly the EXEC cycle
//   Jump, Branch,       control decision, sampled in EXEC
//   branch_ne, jr_sel,
//   zero, rs_data
//   pc, pc_plus4        current PC and its link value
//   halted, fault       sticky stop flags
//   instr_count,        performance counters
//   stall_count
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        branch_ne,
  input  logic        jr_sel,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_EXEC, ST_HALT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc_r;
  logic [31:0]        instr_p0;
  logic               fault_r;
  logic               halt_op;
  logic               jr_fault;
  logic               advance;
  logic signed [31:0] br_off;
  logic [31:0]        next_pc;

  assign opcode   = instr_p0[31:26];
  assign instr    = instr_p0;
  assign pc       = pc_r;
  assign pc_plus4 = pc_r + 32'd4;
  assign imem_addr = pc_r;
  assign fault    = fault_r;

  assign halt_op  = (opcode == HALT_OPCODE);
  assign jr_fault = jr_sel && (rs_data[1:0] != 2'b00);
  // The halt opcode wins over a faulting jr: the instruction simply stops.
  assign advance  = (state == ST_EXEC) && !halt_op && !jr_fault;

  // Branch displacement: sign-extended word offset relative to pc+4.
  assign br_off = {{14{instr_p0[15]}}, instr_p0[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr_sel)
      next_pc = rs_data;
    else if (Jump)
      next_pc = {pc_plus4[31:28], instr_p0[25:0], 2'b00};
    else if (Branch && (zero ^ branch_ne))
      next_pc = pc_plus4 + $unsigned(br_off);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RST;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ready) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (halt_op || jr_fault) ? ST_HALT : ST_FETCH;
      default:  state_nxt = ST_HALT;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem_req    = (state == ST_FETCH);
    instr_valid = (state == ST_EXEC);
    halted      = (state == ST_HALT);
  end

  // Fetch -> execute boundary: instruction latch, PC and fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r     <= RESET_PC;
      instr_p0 <= 32'd0;
      fault_r  <= 1'b0;
    end else begin
      if (state == ST_FETCH && imem_ready)
        instr_p0 <= imem_rdata;
      if (advance)
        pc_r <= next_pc;
      if (state == ST_EXEC && !halt_op && jr_fault)
        fault_r <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] icnt_r, scnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_r <= 32'd0;
      scnt_r <= 32'd0;
    end else begin
      if (state == ST_EXEC)
        icnt_r <= sat_inc(icnt_r);
      if (state == ST_FETCH && !imem_ready)
        scnt_r <= sat_inc(scnt_r);
    end
  end

  assign instr_count = icnt_r;
  assign stall_count = scnt_r;
`else
  assign instr_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule
